// File: rtl/wrf_frame_gen_if.sv
// WR fabric (pipelined Wishbone, 16-bit) source/sink bundle.
// The generator drives the master side; the downstream sink drives stall/ack/err.
interface wrf_if;
  logic [1:0]  adr;
  logic [15:0] dat;
  logic [1:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        stall;
  logic        ack;
  logic        err;

  modport master (output adr, dat, sel, cyc, stb, we, input stall, ack, err);
  modport slave  (input adr, dat, sel, cyc, stb, we, output stall, ack, err);
endinterface

// File: rtl/wrf_frame_gen.sv
// Ethernet frame traffic generator on a WR fabric source.
// Each frame: status word, 14-byte header, seq/pattern payload, OOB word.
module wrf_frame_gen #(
  parameter logic [47:0] g_dst_mac   = 48'h0050cafebabe,
  parameter logic [47:0] g_src_mac   = 48'h010203040506,
  parameter logic [15:0] g_ethertype = 16'h88f7,
  parameter int          g_max_size  = 1518,
  parameter int          g_gap       = 4
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] n_frames_i,
  input  logic [10:0] size_min_i,
  input  logic [10:0] size_max_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] frames_sent_o,
  wrf_if.master       src
);

  localparam logic [10:0] MAXSZ    = 11'(g_max_size);
  localparam int          GAPN     = (g_gap < 1) ? 1 : g_gap;
  localparam logic [15:0] GAP_LAST = 16'(GAPN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STATUS, S_HDR, S_PAYLOAD, S_OOB, S_DRAIN, S_GAP, S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d, seq_q, seq_d, sent_q, sent_d, gap_q, gap_d;
  logic [10:0] min_q, min_d, max_q, max_d, size_q, size_d;
  logic [10:0] widx_q, widx_d, out_q, out_d;
  logic        err_q, err_d;

  logic        active, cyc, stb, xfer, ack_v, err_hit, frame_end, last_pw;
  logic [10:0] plen, nwords, bidx, cmin, cmax;

  function automatic logic [10:0] clamp_sz(input logic [10:0] s);
    if (s < 11'd16) return 11'd16;
    if (s > MAXSZ)  return MAXSZ;
    return s;
  endfunction

  assign active  = (state_q == S_STATUS) || (state_q == S_HDR) ||
                   (state_q == S_PAYLOAD) || (state_q == S_OOB);
  assign cyc     = active || (state_q == S_DRAIN);
  // An error withdraws the strobe in the same cycle so nothing more transfers.
  assign stb     = active && !src.err;
  assign xfer    = stb && !src.stall;
  assign ack_v   = cyc && src.ack;
  assign err_hit = cyc && src.err;

  assign plen    = size_q - 11'd14;
  assign nwords  = (plen + 11'd1) >> 1;
  assign last_pw = (widx_q == nwords - 11'd1);
  assign bidx    = {widx_q[9:0], 1'b0};
  assign cmin    = clamp_sz(size_min_i);
  assign cmax    = clamp_sz(size_max_i);

  assign src.cyc       = cyc;
  assign src.stb       = stb;
  assign src.we        = 1'b1;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done_o        = (state_q == S_FINISH);
  assign error_o       = err_q;
  assign frames_sent_o = sent_q;

  // Output word is a pure function of state/index, so it holds while stalled.
  always_comb begin
    src.adr = 2'b00;
    src.dat = 16'h0000;
    src.sel = 2'b00;
    case (state_q)
      S_STATUS: begin
        src.adr = 2'b10;
        src.sel = 2'b11;
      end
      S_HDR: begin
        src.sel = 2'b11;
        case (widx_q[2:0])
          3'd0:    src.dat = g_dst_mac[47:32];
          3'd1:    src.dat = g_dst_mac[31:16];
          3'd2:    src.dat = g_dst_mac[15:0];
          3'd3:    src.dat = g_src_mac[47:32];
          3'd4:    src.dat = g_src_mac[31:16];
          3'd5:    src.dat = g_src_mac[15:0];
          default: src.dat = g_ethertype;
        endcase
      end
      S_PAYLOAD: begin
        src.sel = 2'b11;
        if (widx_q == 11'd0) begin
          src.dat = seq_q;
        end else if (plen[0] && last_pw) begin
          src.dat = {bidx[7:0], 8'h00};
          src.sel = 2'b10;
        end else begin
          src.dat = {bidx[7:0], bidx[7:0] | 8'h01};
        end
      end
      S_OOB: begin
        src.adr = 2'b01;
        src.dat = seq_q;
        src.sel = 2'b11;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    seq_d     = seq_q;
    sent_d    = sent_q;
    gap_d     = gap_q;
    min_d     = min_q;
    max_d     = max_q;
    size_d    = size_q;
    widx_d    = widx_q;
    err_d     = err_q;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        n_d    = n_frames_i;
        min_d  = cmin;
        max_d  = (cmin > cmax) ? cmin : cmax;
        size_d = cmin;
        seq_d  = 16'd0;
        sent_d = 16'd0;
        err_d  = 1'b0;
        widx_d = 11'd0;
        gap_d  = 16'd0;
        // An empty burst spends one GAP cycle busy, then finishes.
        state_d = (n_frames_i == 16'd0) ? S_GAP : S_STATUS;
      end
      S_STATUS: if (xfer) begin
        state_d = S_HDR;
        widx_d  = 11'd0;
      end
      S_HDR: if (xfer) begin
        if (widx_q == 11'd6) begin
          state_d = S_PAYLOAD;
          widx_d  = 11'd0;
        end else begin
          widx_d = widx_q + 11'd1;
        end
      end
      S_PAYLOAD: if (xfer) begin
        if (last_pw) state_d = S_OOB;
        else         widx_d  = widx_q + 11'd1;
      end
      S_OOB:   if (xfer) state_d = S_DRAIN;
      S_DRAIN: if (out_q == 11'd0) frame_end = 1'b1;
      S_GAP: begin
        if (gap_q == 16'd0) state_d = (sent_q < n_q) ? S_STATUS : S_FINISH;
        else                gap_d   = gap_q - 16'd1;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (err_hit) begin
      err_d     = 1'b1;
      frame_end = 1'b1;
    end

    if (frame_end) begin
      state_d = S_GAP;
      gap_d   = GAP_LAST;
      widx_d  = 11'd0;
      sent_d  = sent_q + 16'd1;
      seq_d   = seq_q + 16'd1;
      size_d  = (size_q >= max_q) ? min_q : size_q + 11'd1;
    end

    // Issue and ack counts move independently; stray acks never underflow.
    if (frame_end)
      out_d = 11'd0;
    else
      out_d = out_q + {10'd0, xfer} - {10'd0, ack_v && ((out_q != 11'd0) || xfer)};
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      seq_q   <= '0;
      sent_q  <= '0;
      gap_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      size_q  <= '0;
      widx_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      seq_q   <= seq_d;
      sent_q  <= sent_d;
      gap_q   <= gap_d;
      min_q   <= min_d;
      max_q   <= max_d;
      size_q  <= size_d;
      widx_q  <= widx_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wrf_frame_gen.sv
// Bench for wrf_frame_gen: a sink model with random stall / delayed ack captures
// the word stream, which is compared against a byte-level frame model.
module tb_wrf_frame_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [15:0] n_frames;
  logic [10:0] smin, smax;
  logic        busy, done, error;
  logic [15:0] sent;

  wrf_if src_if();

  wrf_frame_gen dut (
    .clk_sys_i(clk), .rst_i(rst), .start_i(start),
    .n_frames_i(n_frames), .size_min_i(smin), .size_max_i(smax),
    .busy_o(busy), .done_o(done), .error_o(error), .frames_sent_o(sent),
    .src(src_if)
  );

  typedef struct packed { logic [1:0] adr; logic [15:0] dat; logic [1:0] sel; } word_t;

  word_t cap_q[$], exp_q[$];
  int    cap_len_q[$], exp_len_q[$];
  int    checks = 0, fails = 0;

  bit stall_en = 0;
  int ack_dly  = 1;
  int err_at   = -1;
  int rises, min_gap, gap_cnt, ack_short, done_cycles, fw, facks, fr_cnt;
  bit prev_cyc, prev_err, err_seen, stb_at_err, cyc_after_err;
  bit hist[8];

  task automatic clear_stats();
    cap_q.delete(); cap_len_q.delete();
    rises = 0; min_gap = 100000; gap_cnt = 0; ack_short = 0; done_cycles = 0;
    fw = 0; facks = 0; fr_cnt = 0;
    err_seen = 0; stb_at_err = 1; cyc_after_err = 1;
  endtask

  // Sink and monitor: drive stall/ack/err mid-cycle, then observe the cycle.
  initial begin
    bit xfer;
    src_if.stall = 0; src_if.ack = 0; src_if.err = 0;
    prev_cyc = 0; prev_err = 0;
    foreach (hist[i]) hist[i] = 0;
    clear_stats();
    forever begin
      @(negedge clk);
      src_if.stall = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      src_if.ack   = hist[ack_dly-1];
      if (err_at >= 0 && src_if.cyc && fr_cnt == 0 && fw == err_at) begin
        src_if.err = 1'b1;
        err_at = -1;
      end else begin
        src_if.err = 1'b0;
      end
      #1;
      xfer = src_if.cyc && src_if.stb && !src_if.stall;
      if (src_if.cyc && !prev_cyc) begin
        if (rises > 0 && gap_cnt < min_gap) min_gap = gap_cnt;
        rises++; fw = 0; facks = 0;
      end
      if (!src_if.cyc && prev_cyc) begin
        cap_len_q.push_back(fw);
        if (facks != fw) ack_short++;
        fr_cnt++; gap_cnt = 0;
      end
      if (!src_if.cyc) gap_cnt++;
      if (xfer) begin
        cap_q.push_back('{src_if.adr, src_if.dat, src_if.sel});
        fw++;
      end
      if (src_if.cyc && src_if.ack) facks++;
      if (prev_err) cyc_after_err = src_if.cyc;
      if (src_if.err) begin err_seen = 1; stb_at_err = src_if.stb; end
      prev_err = src_if.err;
      if (done) done_cycles++;
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = xfer;
      prev_cyc = src_if.cyc;
    end
  end

  function automatic int clampi(input int v);
    if (v < 16) return 16;
    if (v > 1518) return 1518;
    return v;
  endfunction

  // Reference: assemble each frame as bytes, then pack big-endian into words.
  task automatic model_burst(input int n, input int mn, input int mx);
    int lo, hi, sz;
    logic [15:0] seq;
    logic [7:0]  fb[$];
    logic [47:0] d, s;
    d = 48'h0050cafebabe; s = 48'h010203040506;
    exp_q.delete(); exp_len_q.delete();
    lo = clampi(mn); hi = clampi(mx);
    if (lo > hi) hi = lo;
    sz = lo; seq = 0;
    for (int f = 0; f < n; f++) begin
      fb.delete();
      for (int i = 5; i >= 0; i--) fb.push_back(d[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) fb.push_back(s[i*8 +: 8]);
      fb.push_back(8'h88); fb.push_back(8'hf7);
      for (int k = 0; k < sz - 14; k++)
        fb.push_back(k == 0 ? seq[15:8] : (k == 1 ? seq[7:0] : 8'(k)));
      exp_q.push_back('{2'b10, 16'h0000, 2'b11});
      for (int i = 0; i < fb.size(); i += 2) begin
        if (i + 1 < fb.size()) exp_q.push_back('{2'b00, {fb[i], fb[i+1]}, 2'b11});
        else                   exp_q.push_back('{2'b00, {fb[i], 8'h00}, 2'b10});
      end
      exp_q.push_back('{2'b01, seq, 2'b11});
      exp_len_q.push_back(2 + (fb.size() + 1) / 2);
      sz = (sz == hi) ? lo : sz + 1;
      seq++;
    end
  endtask

  task automatic run_burst(input int n, input int mn, input int mx, output bit timed_out);
    clear_stats();
    @(negedge clk);
    n_frames = 16'(n); smin = 11'(mn); smax = 11'(mx); start = 1;
    @(negedge clk);
    start = 0;
    timed_out = 1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk); #2;
      if (done) begin timed_out = 0; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; n_frames = 0; smin = 0; smax = 0;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (src_if.cyc !== 1'b0) begin fails++; $display("FAIL reset_cyc got %b want 0", src_if.cyc); end
    checks++; if (src_if.stb !== 1'b0) begin fails++; $display("FAIL reset_stb got %b want 0", src_if.stb); end
    checks++; if (src_if.we !== 1'b1) begin fails++; $display("FAIL reset_we got %b want 1", src_if.we); end
    checks++; if ({src_if.adr, src_if.dat, src_if.sel} !== 20'h0) begin fails++; $display("FAIL reset_bus got %h want 0", {src_if.adr, src_if.dat, src_if.sel}); end
    checks++; if ({busy, done, error} !== 3'b000) begin fails++; $display("FAIL reset_status got %b want 000", {busy, done, error}); end
    checks++; if (sent !== 16'd0) begin fails++; $display("FAIL reset_sent got %0d want 0", sent); end
    rst = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_size64();
    bit to;
    run_burst(1, 64, 64, to);
    model_burst(1, 64, 64);
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL s64_timeout got %b want 0", to); end
    checks++; if (cap_q.size() !== 34) begin fails++; $display("FAIL s64_len got %0d want 34", cap_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin fails++; $display("FAIL s64_word %0d got %h want %h", i, cap_q[i], exp_q[i]); end
    end
    if (cap_q.size() >= 10) begin
      checks++; if (cap_q[8].dat !== 16'h0000) begin fails++; $display("FAIL s64_pw0 got %h want 0000", cap_q[8].dat); end
      checks++; if (cap_q[9].dat !== 16'h0203) begin fails++; $display("FAIL s64_pw1 got %h want 0203", cap_q[9].dat); end
    end
    checks++; if (sent !== 16'd1) begin fails++; $display("FAIL s64_sent got %0d want 1", sent); end
    checks++; if (done_cycles !== 1) begin fails++; $display("FAIL s64_done_width got %0d want 1", done_cycles); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL s64_busy got %b want 0", busy); end
    checks++; if (ack_short !== 0) begin fails++; $display("FAIL s64_ack_drain got %0d want 0", ack_short); end
  endtask

  task automatic test_odd65();
    bit to;
    run_burst(1, 65, 65, to);
    model_burst(1, 65, 65);
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL s65_timeout got %b want 0", to); end
    checks++; if (cap_q.size() !== 35) begin fails++; $display("FAIL s65_len got %0d want 35", cap_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin fails++; $display("FAIL s65_word %0d got %h want %h", i, cap_q[i], exp_q[i]); end
    end
    if (cap_q.size() >= 34) begin
      checks++; if ({cap_q[33].sel, cap_q[33].dat} !== {2'b10, 16'h3200}) begin fails++; $display("FAIL s65_last got sel %b dat %h want sel 10 dat 3200", cap_q[33].sel, cap_q[33].dat); end
    end
  endtask

  task automatic test_sweep();
    bit to;
    run_burst(5, 60, 62, to);
    model_burst(5, 60, 62);
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL sweep_timeout got %b want 0", to); end
    checks++; if (cap_len_q != exp_len_q) begin fails++; $display("FAIL sweep_frame_lens got %p want %p", cap_len_q, exp_len_q); end
    checks++; if (cap_q.size() !== exp_q.size()) begin fails++; $display("FAIL sweep_len got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin fails++; $display("FAIL sweep_word %0d got %h want %h", i, cap_q[i], exp_q[i]); end
    end
    checks++; if (min_gap < 4) begin fails++; $display("FAIL sweep_gap got %0d want >=4", min_gap); end
    checks++; if (sent !== 16'd5) begin fails++; $display("FAIL sweep_sent got %0d want 5", sent); end
  endtask

  task automatic test_stall();
    bit to;
    stall_en = 1; ack_dly = 3;
    run_burst(3, 100, 100, to);
    stall_en = 0; ack_dly = 1;
    model_burst(3, 100, 100);
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL stall_timeout got %b want 0", to); end
    checks++; if (cap_q.size() !== exp_q.size()) begin fails++; $display("FAIL stall_len got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin fails++; $display("FAIL stall_word %0d got %h want %h", i, cap_q[i], exp_q[i]); end
    end
    checks++; if (ack_short !== 0) begin fails++; $display("FAIL stall_ack_drain got %0d frames short want 0", ack_short); end
    checks++; if (sent !== 16'd3) begin fails++; $display("FAIL stall_sent got %0d want 3", sent); end
  endtask

  task automatic test_zero_clamp();
    bit to;
    clear_stats();
    @(negedge clk);
    n_frames = 0; smin = 11'd64; smax = 11'd64; start = 1;
    @(negedge clk);
    start = 0;
    #2;
    checks++; if ({busy, done} !== 2'b10) begin fails++; $display("FAIL zero_c1 busy/done got %b want 10", {busy, done}); end
    @(negedge clk); #2;
    checks++; if ({busy, done} !== 2'b01) begin fails++; $display("FAIL zero_c2 busy/done got %b want 01", {busy, done}); end
    @(negedge clk); #2;
    checks++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL zero_c3 busy/done got %b want 00", {busy, done}); end
    repeat (3) @(negedge clk);
    checks++; if (rises !== 0) begin fails++; $display("FAIL zero_cyc got %0d cyc rises want 0", rises); end

    run_burst(2, 5, 3, to);
    model_burst(2, 5, 3);
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL clamp_timeout got %b want 0", to); end
    checks++; if (cap_len_q != exp_len_q) begin fails++; $display("FAIL clamp_frame_lens got %p want %p", cap_len_q, exp_len_q); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin fails++; $display("FAIL clamp_word %0d got %h want %h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_error();
    bit to;
    err_at = 10;
    run_burst(2, 64, 64, to);
    err_at = -1;
    model_burst(2, 64, 64);
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL err_timeout got %b want 0", to); end
    checks++; if (err_seen !== 1'b1) begin fails++; $display("FAIL err_injected got %b want 1", err_seen); end
    checks++; if (stb_at_err !== 1'b0) begin fails++; $display("FAIL err_stb got %b want 0", stb_at_err); end
    checks++; if (cyc_after_err !== 1'b0) begin fails++; $display("FAIL err_cyc_next got %b want 0", cyc_after_err); end
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL err_flag got %b want 1", error); end
    checks++; if (sent !== 16'd2) begin fails++; $display("FAIL err_sent got %0d want 2", sent); end
    checks++; if (cap_q.size() !== 44) begin fails++; $display("FAIL err_len got %0d want 44", cap_q.size()); end
    if (cap_q.size() == 44) begin
      for (int i = 0; i < 10; i++) begin
        checks++; if (cap_q[i] !== exp_q[i]) begin fails++; $display("FAIL err_f0_word %0d got %h want %h", i, cap_q[i], exp_q[i]); end
      end
      for (int i = 0; i < 34; i++) begin
        checks++; if (cap_q[10+i] !== exp_q[34+i]) begin fails++; $display("FAIL err_f1_word %0d got %h want %h", i, cap_q[10+i], exp_q[34+i]); end
      end
      checks++; if (cap_q[43].dat !== 16'd1) begin fails++; $display("FAIL err_f1_seq got %0d want 1", cap_q[43].dat); end
    end
  endtask

  task automatic test_midreset();
    bit hit;
    clear_stats();
    @(negedge clk);
    n_frames = 3; smin = 11'd200; smax = 11'd200; start = 1;
    @(negedge clk);
    start = 0;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (cap_q.size() > 20) begin hit = 1; break; end
    end
    checks++; if (hit !== 1'b1) begin fails++; $display("FAIL mrst_progress got %0d words want >20", cap_q.size()); end
    @(negedge clk);
    rst = 1;
    @(negedge clk); #2;
    checks++; if ({src_if.cyc, src_if.stb, busy} !== 3'b000) begin fails++; $display("FAIL mrst_drop cyc/stb/busy got %b want 000", {src_if.cyc, src_if.stb, busy}); end
    checks++; if (sent !== 16'd0) begin fails++; $display("FAIL mrst_sent got %0d want 0", sent); end
    rst = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_size64();
    test_odd65();
    test_sweep();
    test_stall();
    test_zero_clamp();
    test_error();
    test_midreset();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
